id_decoder: RTL and testbench

ID_DECODER -- requirements
Module: id_decoder

---
 rtl/id_decoder.sv | 123 ++++++++++++
 tb/tb_id_decoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/id_decoder.sv
// Registered instruction decoder: splits a 17-bit instruction into register
// addresses and datapath control signals, one cycle after sampling.
module id_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [16:0] instruction,
  output logic        RW,
  output logic [2:0]  DA,
  output logic [1:0]  MD,
  output logic [1:0]  BS,
  output logic        PS,
  output logic        MW,
  output logic [3:0]  FS,
  output logic        MA,
  output logic        MB,
  output logic [2:0]  AA,
  output logic [2:0]  BA,
  output logic        CS,
  output logic [2:0]  SH,
  output logic        output_write_enable
);

  typedef enum logic [4:0] {
    OP_NOP  = 5'b00000, OP_MOVA = 5'b00001, OP_INC  = 5'b00010,
    OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_DEC  = 5'b00101,
    OP_AND  = 5'b00110, OP_OR   = 5'b00111, OP_XOR  = 5'b01000,
    OP_NOT  = 5'b01001, OP_MOVB = 5'b01010, OP_SHR  = 5'b01011,
    OP_SHL  = 5'b01100, OP_LD   = 5'b01101, OP_ST   = 5'b01110,
    OP_OUT  = 5'b01111, OP_LDI  = 5'b10000, OP_ADI  = 5'b10001,
    OP_SLT  = 5'b10010, OP_BRZ  = 5'b10100, OP_BNZ  = 5'b10101,
    OP_JMR  = 5'b10110, OP_JMP  = 5'b10111, OP_JAL  = 5'b11000
  } opcode_e;

  typedef struct packed {
    logic       rw;
    logic [2:0] da;
    logic [1:0] md;
    logic [1:0] bs;
    logic       ps;
    logic       mw;
    logic [3:0] fs;
    logic       ma;
    logic       mb;
    logic [2:0] aa;
    logic [2:0] ba;
    logic       cs;
    logic [2:0] sh;
    logic       owe;
  } ctrl_t;

  ctrl_t ctrl_d, ctrl_q;

  always_comb begin
    // NOTE: assigning every field up front keeps this block latch-free; the
    // case below only overrides what each opcode changes.
    ctrl_d    = '0;
    ctrl_d.da = instruction[11:9];
    ctrl_d.aa = instruction[8:6];
    ctrl_d.ba = instruction[5:3];
    ctrl_d.sh = instruction[2:0];
    case (instruction[16:12])
      OP_MOVA: begin ctrl_d.rw = 1'b1; ctrl_d.fs = 4'b0000; end
      OP_INC:  begin ctrl_d.rw = 1'b1; ctrl_d.fs = 4'b0001; end
      OP_ADD:  begin ctrl_d.rw = 1'b1; ctrl_d.fs = 4'b0010; end
      OP_SUB:  begin ctrl_d.rw = 1'b1; ctrl_d.fs = 4'b0101; end
      OP_DEC:  begin ctrl_d.rw = 1'b1; ctrl_d.fs = 4'b0110; end
      OP_AND:  begin ctrl_d.rw = 1'b1; ctrl_d.fs = 4'b1000; end
      OP_OR:   begin ctrl_d.rw = 1'b1; ctrl_d.fs = 4'b1001; end
      OP_XOR:  begin ctrl_d.rw = 1'b1; ctrl_d.fs = 4'b1010; end
      OP_NOT:  begin ctrl_d.rw = 1'b1; ctrl_d.fs = 4'b1011; end
      OP_MOVB: begin ctrl_d.rw = 1'b1; ctrl_d.fs = 4'b1100; end
      OP_SHR:  begin ctrl_d.rw = 1'b1; ctrl_d.fs = 4'b1101; end
      OP_SHL:  begin ctrl_d.rw = 1'b1; ctrl_d.fs = 4'b1110; end
      OP_LD:   begin ctrl_d.rw = 1'b1; ctrl_d.md = 2'b01; end
      OP_ST:   ctrl_d.mw  = 1'b1;
      OP_OUT:  ctrl_d.owe = 1'b1;
      OP_LDI:  begin
        ctrl_d.rw = 1'b1; ctrl_d.mb = 1'b1; ctrl_d.fs = 4'b1100; ctrl_d.cs = 1'b0;
      end
      OP_ADI:  begin
        ctrl_d.rw = 1'b1; ctrl_d.mb = 1'b1; ctrl_d.fs = 4'b0010; ctrl_d.cs = 1'b1;
      end
      OP_SLT:  begin ctrl_d.rw = 1'b1; ctrl_d.md = 2'b10; ctrl_d.fs = 4'b0101; end
      OP_BRZ:  begin
        ctrl_d.bs = 2'b01; ctrl_d.ps = 1'b0; ctrl_d.mb = 1'b1; ctrl_d.cs = 1'b1;
      end
      OP_BNZ:  begin
        ctrl_d.bs = 2'b01; ctrl_d.ps = 1'b1; ctrl_d.mb = 1'b1; ctrl_d.cs = 1'b1;
      end
      OP_JMR:  ctrl_d.bs = 2'b10;
      OP_JMP:  begin ctrl_d.bs = 2'b11; ctrl_d.mb = 1'b1; ctrl_d.cs = 1'b1; end
      // Jump-and-link writes PC (A-bus from PC, pass-through) into DR.
      OP_JAL:  begin
        ctrl_d.rw = 1'b1; ctrl_d.ma = 1'b1; ctrl_d.fs = 4'b0000;
        ctrl_d.bs = 2'b11; ctrl_d.mb = 1'b1; ctrl_d.cs = 1'b1;
      end
      default: ;  // NOP and undefined opcodes keep the defaults
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples the pre-edge value regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl_q <= '0;
    else        ctrl_q <= ctrl_d;
  end

  assign RW                  = ctrl_q.rw;
  assign DA                  = ctrl_q.da;
  assign MD                  = ctrl_q.md;
  assign BS                  = ctrl_q.bs;
  assign PS                  = ctrl_q.ps;
  assign MW                  = ctrl_q.mw;
  assign FS                  = ctrl_q.fs;
  assign MA                  = ctrl_q.ma;
  assign MB                  = ctrl_q.mb;
  assign AA                  = ctrl_q.aa;
  assign BA                  = ctrl_q.ba;
  assign CS                  = ctrl_q.cs;
  assign SH                  = ctrl_q.sh;
  assign output_write_enable = ctrl_q.owe;

endmodule

// File: tb/tb_id_decoder.sv
// Self-checking bench for id_decoder: directed cases plus random instructions
// compared against a rule-based reference model.
module tb_id_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [16:0] instruction = '0;
  logic        RW, PS, MW, MA, MB, CS, output_write_enable;
  logic [2:0]  DA, AA, BA, SH;
  logic [1:0]  MD, BS;
  logic [3:0]  FS;

  int errors = 0;
  int checks = 0;

  id_decoder dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .RW(RW), .DA(DA), .MD(MD), .BS(BS), .PS(PS), .MW(MW), .FS(FS),
    .MA(MA), .MB(MB), .AA(AA), .BA(BA), .CS(CS), .SH(SH),
    .output_write_enable(output_write_enable)
  );

  always #5 clk = ~clk;

  // {RW,DA,MD,BS,PS,MW,FS,MA,MB,AA,BA,CS,SH,OWE}
  wire [26:0] dut_vec = {RW, DA, MD, BS, PS, MW, FS, MA, MB, AA, BA, CS, SH,
                         output_write_enable};

  // Reference: each control signal stated as the set of opcodes that drive it.
  function automatic logic [26:0] model(input logic [16:0] ins);
    int         op;
    logic       rw, mw, owe, ps, ma, mb, cs;
    logic [1:0] md, bs;
    logic [3:0] fs;
    logic [3:0] alu_fs [1:12];
    alu_fs = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12,
               4'd13, 4'd14};
    op  = int'(ins[16:12]);
    rw  = (op >= 1 && op <= 13) || (op >= 16 && op <= 18) || op == 24;
    mw  = op == 14;
    owe = op == 15;
    md  = (op == 13) ? 2'd1 : (op == 18) ? 2'd2 : 2'd0;
    bs  = (op == 20 || op == 21) ? 2'd1 : (op == 22) ? 2'd2 :
          (op == 23 || op == 24) ? 2'd3 : 2'd0;
    ps  = op == 21;
    ma  = op == 24;
    mb  = op == 16 || op == 17 || op == 20 || op == 21 || op == 23 || op == 24;
    cs  = op == 17 || op == 20 || op == 21 || op == 23 || op == 24;
    if (op >= 1 && op <= 12) fs = alu_fs[op];
    else if (op == 16)       fs = 4'd12;
    else if (op == 17)       fs = 4'd2;
    else if (op == 18)       fs = 4'd5;
    else                     fs = 4'd0;
    return {rw, ins[11:9], md, bs, ps, mw, fs, ma, mb, ins[8:6], ins[5:3], cs,
            ins[2:0], owe};
  endfunction

  task automatic apply(input logic [16:0] ins);
    @(negedge clk);
    instruction = ins;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    instruction = 17'h1FFFF;
    #1;
    checks++;
    if (dut_vec !== 27'd0) begin
      errors++; $display("FAIL reset_async outputs=%h required=0", dut_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    instruction = '0;
    @(negedge clk);
    checks++;
    if (dut_vec !== 27'd0) begin
      errors++; $display("FAIL nop outputs=%h required=0", dut_vec);
    end
  endtask

  task automatic test_out;
    logic [16:0] ins = 17'b01111_010_110_001_000;
    apply(ins);
    checks++;
    if ({output_write_enable, RW, MW, DA, AA, BA, SH} !== {3'b100, 3'd2, 3'd6, 3'd1, 3'd0}) begin
      errors++; $display("FAIL out_fields got=%b", {output_write_enable, RW, MW, DA, AA, BA, SH});
    end
    checks++;
    if (dut_vec !== model(ins)) begin
      errors++; $display("FAIL out_full outputs=%h required=%h", dut_vec, model(ins));
    end
  endtask

  task automatic test_brz;
    logic [16:0] ins = 17'b10100_100_010_010000;
    apply(ins);
    checks++;
    if ({BS, PS, MB, CS, RW, DA, AA, BA, SH} !== {2'b01, 4'b0110, 3'd4, 3'd2, 3'd2, 3'd0}) begin
      errors++; $display("FAIL brz_fields got=%b", {BS, PS, MB, CS, RW, DA, AA, BA, SH});
    end
    checks++;
    if (dut_vec !== model(ins)) begin
      errors++; $display("FAIL brz_full outputs=%h required=%h", dut_vec, model(ins));
    end
  endtask

  task automatic test_ldi;
    logic [16:0] ins = 17'b10000_010_010_010000;
    apply(ins);
    checks++;
    if ({RW, MB, FS, CS, MD, DA, AA, BA} !== {2'b11, 4'b1100, 1'b0, 2'b00, 3'd2, 3'd2, 3'd2}) begin
      errors++; $display("FAIL ldi_fields got=%b", {RW, MB, FS, CS, MD, DA, AA, BA});
    end
  endtask

  task automatic test_undefined;
    logic [16:0] ins;
    logic [4:0]  undef_ops [8] = '{5'b10011, 5'b11001, 5'b11010, 5'b11011,
                                   5'b11100, 5'b11101, 5'b11110, 5'b11111};
    for (int i = 0; i < 8; i++) begin
      ins = {undef_ops[i], 12'($urandom)};
      apply(ins);
      checks++;
      if ({RW, MD, BS, PS, MW, FS, MA, MB, CS, output_write_enable} !== 15'd0 ||
          {DA, AA, BA, SH} !== ins[11:0]) begin
        errors++;
        $display("FAIL undefined_op op=%b outputs=%h required=%h", undef_ops[i],
                 dut_vec, model(ins));
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [16:0] ins = {5'b00011, 12'($urandom)};
    apply(ins);
    checks++;
    if (RW !== 1'b1) begin
      errors++; $display("FAIL add_rw RW=%b required=1", RW);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (RW !== 1'b0 || dut_vec !== 27'd0) begin
      errors++; $display("FAIL reset_mid outputs=%h required=0", dut_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dut_vec !== model(ins)) begin
      errors++; $display("FAIL reset_release outputs=%h required=%h", dut_vec, model(ins));
    end
  endtask

  task automatic test_random;
    logic [16:0] prev = '0;
    for (int i = 0; i <= 400; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (dut_vec !== model(prev)) begin
          errors++;
          $display("FAIL random ins=%b outputs=%h required=%h", prev, dut_vec, model(prev));
        end
        checks++;
        if (int'(RW) + int'(MW) + int'(output_write_enable) > 1) begin
          errors++;
          $display("FAIL exclusive_writes ins=%b RW=%b MW=%b OWE=%b required<=1 set",
                   prev, RW, MW, output_write_enable);
        end
      end
      instruction = 17'($urandom);
      prev = instruction;
    end
  endtask

  initial begin
    test_reset;
    test_out;
    test_brz;
    test_ldi;
    test_undefined;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
